// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and helpers for the two-port cache arbiter.
// Port 0 is instruction fetch, port 1 is data load/store.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACTIVE = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // A tie goes to the port that was not served last (round-robin) or to port 0.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last, input logic rr_en);
        if (req0 && req1)
            return rr_en ? ~last : PORT_I;
        return req1 ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_sat_counter.sv
// Saturating up-counter used for the per-port performance statistics.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache between the fetch port and the load/store port; grant is
// held until the cache stops missing, then one RESP cycle returns the data.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_rd_req,
    input  logic             p0_wr_req,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wr_data,
    output logic [31:0]      p0_rd_data,
    output logic             p0_done,
    input  logic             p1_rd_req,
    input  logic             p1_wr_req,
    input  logic [31:0]      p1_addr,
    input  logic [31:0]      p1_wr_data,
    output logic [31:0]      p1_rd_data,
    output logic             p1_done,
    output logic [31:0]      c_addr,
    output logic             c_rd_req,
    output logic             c_wr_req,
    output logic [31:0]      c_wr_data,
    input  logic [31:0]      c_rd_data,
    input  logic             c_miss,
    output logic             owner,
    output logic             busy,
    output logic [CNT_W-1:0] p0_acc_cnt,
    output logic [CNT_W-1:0] p1_acc_cnt,
    output logic [CNT_W-1:0] p0_miss_cyc,
    output logic [CNT_W-1:0] p1_miss_cyc
);

    arb_state_t  state;
    logic        last_owner;
    logic [31:0] p0_hold, p1_hold;
    logic        req0, req1, active, resp;
    logic        sel_rd, sel_wr;
    logic [31:0] sel_addr, sel_wdata;

    assign req0   = p0_rd_req | p0_wr_req;
    assign req1   = p1_rd_req | p1_wr_req;
    assign active = (state == ARB_ACTIVE);
    assign resp   = (state == ARB_RESP);
    assign busy   = active | resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= PORT_I;
            last_owner <= PORT_D;
            p0_hold    <= '0;
            p1_hold    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (req0 || req1) begin
                        owner <= pick_winner(req0, req1, last_owner, RR_EN);
                        state <= ARB_ACTIVE;
                    end
                end
                ARB_ACTIVE: begin
                    if (!c_miss) begin
                        state      <= ARB_RESP;
                        last_owner <= owner;
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                    if (owner == PORT_I)
                        p0_hold <= c_rd_data;
                    else
                        p1_hold <= c_rd_data;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Cache side follows the owner's live inputs; a read wins over a write.
    assign sel_rd    = (owner == PORT_I) ? p0_rd_req  : p1_rd_req;
    assign sel_wr    = (owner == PORT_I) ? p0_wr_req  : p1_wr_req;
    assign sel_addr  = (owner == PORT_I) ? p0_addr    : p1_addr;
    assign sel_wdata = (owner == PORT_I) ? p0_wr_data : p1_wr_data;

    assign c_rd_req  = active & sel_rd;
    assign c_wr_req  = active & sel_wr & ~sel_rd;
    assign c_addr    = active ? sel_addr  : '0;
    assign c_wr_data = active ? sel_wdata : '0;

    assign p0_done    = resp & (owner == PORT_I);
    assign p1_done    = resp & (owner == PORT_D);
    assign p0_rd_data = p0_done ? c_rd_data : p0_hold;
    assign p1_rd_data = p1_done ? c_rd_data : p1_hold;

    // Counter order: p0 acc, p1 acc, p0 miss, p1 miss.
    logic [3:0]            cnt_inc;
    logic [3:0][CNT_W-1:0] cnt_val;

    assign cnt_inc[0] = active & ~c_miss & (owner == PORT_I);
    assign cnt_inc[1] = active & ~c_miss & (owner == PORT_D);
    assign cnt_inc[2] = active &  c_miss & (owner == PORT_I);
    assign cnt_inc[3] = active &  c_miss & (owner == PORT_D);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (cnt_inc[gi]),
                .cnt (cnt_val[gi])
            );
        end
    endgenerate

    assign p0_acc_cnt  = cnt_val[0];
    assign p1_acc_cnt  = cnt_val[1];
    assign p0_miss_cyc = cnt_val[2];
    assign p1_miss_cyc = cnt_val[3];

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a round-robin instance on a small
// cache model, plus fixed-priority and 4-bit-counter instances on a stub cache.
module tb_cache_port_arbiter;

    logic        clk, rst;
    logic        p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
    logic [31:0] p0_addr, p0_wr_data, p1_addr, p1_wr_data;
    logic [31:0] p0_rd_data, p1_rd_data;
    logic        p0_done, p1_done;
    logic [31:0] c_addr, c_wr_data, c_rd_data;
    logic        c_rd_req, c_wr_req, c_miss;
    logic        owner, busy;
    logic [31:0] p0_acc_cnt, p1_acc_cnt, p0_miss_cyc, p1_miss_cyc;

    logic        b_rst, b_p0_rd, b_p1_rd, b_miss;
    logic [31:0] b_zero;
    logic [31:0] f_p0_rd_data, f_p1_rd_data, f_c_addr, f_c_wr_data;
    logic        f_p0_done, f_p1_done, f_c_rd_req, f_c_wr_req, f_owner, f_busy;
    logic [31:0] f_p0_acc, f_p1_acc, f_p0_miss, f_p1_miss;
    logic [31:0] s_p0_rd_data, s_p1_rd_data, s_c_addr, s_c_wr_data;
    logic        s_p0_done, s_p1_done, s_c_rd_req, s_c_wr_req, s_owner, s_busy;
    logic [3:0]  s_p0_acc, s_p1_acc, s_p0_miss, s_p1_miss;

    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_dat;
    logic [31:0] mem [0:255];

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Cache model: data registered at the accepting edge (miss low).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rd_data <= '0;
        end else begin
            if (pre_we) mem[pre_idx] <= pre_dat;
            if (c_rd_req && !c_miss) c_rd_data <= mem[c_addr[9:2]];
            if (c_wr_req && !c_miss) mem[c_addr[9:2]] <= c_wr_data;
        end
    end

    cache_port_arbiter #(.RR_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr),
        .p0_wr_data(p0_wr_data), .p0_rd_data(p0_rd_data), .p0_done(p0_done),
        .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req), .p1_addr(p1_addr),
        .p1_wr_data(p1_wr_data), .p1_rd_data(p1_rd_data), .p1_done(p1_done),
        .c_addr(c_addr), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req),
        .c_wr_data(c_wr_data), .c_rd_data(c_rd_data), .c_miss(c_miss),
        .owner(owner), .busy(busy),
        .p0_acc_cnt(p0_acc_cnt), .p1_acc_cnt(p1_acc_cnt),
        .p0_miss_cyc(p0_miss_cyc), .p1_miss_cyc(p1_miss_cyc)
    );

    cache_port_arbiter #(.RR_EN(1'b0), .CNT_W(32)) dut_fp (
        .clk(clk), .rst(b_rst),
        .p0_rd_req(b_p0_rd), .p0_wr_req(1'b0), .p0_addr(32'h100),
        .p0_wr_data(b_zero), .p0_rd_data(f_p0_rd_data), .p0_done(f_p0_done),
        .p1_rd_req(b_p1_rd), .p1_wr_req(1'b0), .p1_addr(32'h200),
        .p1_wr_data(b_zero), .p1_rd_data(f_p1_rd_data), .p1_done(f_p1_done),
        .c_addr(f_c_addr), .c_rd_req(f_c_rd_req), .c_wr_req(f_c_wr_req),
        .c_wr_data(f_c_wr_data), .c_rd_data(b_zero), .c_miss(b_miss),
        .owner(f_owner), .busy(f_busy),
        .p0_acc_cnt(f_p0_acc), .p1_acc_cnt(f_p1_acc),
        .p0_miss_cyc(f_p0_miss), .p1_miss_cyc(f_p1_miss)
    );

    cache_port_arbiter #(.RR_EN(1'b1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(b_rst),
        .p0_rd_req(b_p0_rd), .p0_wr_req(1'b0), .p0_addr(32'h100),
        .p0_wr_data(b_zero), .p0_rd_data(s_p0_rd_data), .p0_done(s_p0_done),
        .p1_rd_req(b_p1_rd), .p1_wr_req(1'b0), .p1_addr(32'h200),
        .p1_wr_data(b_zero), .p1_rd_data(s_p1_rd_data), .p1_done(s_p1_done),
        .c_addr(s_c_addr), .c_rd_req(s_c_rd_req), .c_wr_req(s_c_wr_req),
        .c_wr_data(s_c_wr_data), .c_rd_data(b_zero), .c_miss(b_miss),
        .owner(s_owner), .busy(s_busy),
        .p0_acc_cnt(s_p0_acc), .p1_acc_cnt(s_p1_acc),
        .p0_miss_cyc(s_p0_miss), .p1_miss_cyc(s_p1_miss)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (owner !== 1'b0) begin errs++; $display("FAIL reset_owner: got %0b want 0", owner); end
        checks++; if ({p0_done, p1_done, c_rd_req, c_wr_req} !== 4'b0) begin errs++; $display("FAIL reset_strobes: got %b want 0000", {p0_done, p1_done, c_rd_req, c_wr_req}); end
        checks++; if (c_addr !== 32'h0) begin errs++; $display("FAIL reset_c_addr: got %h want 0", c_addr); end
        checks++; if ((p0_acc_cnt | p1_acc_cnt | p0_miss_cyc | p1_miss_cyc) !== 32'h0) begin errs++; $display("FAIL reset_counters: got nonzero %h", p0_acc_cnt | p1_acc_cnt | p0_miss_cyc | p1_miss_cyc); end
        checks++; if ((p0_rd_data | p1_rd_data) !== 32'h0) begin errs++; $display("FAIL reset_rd_data: got %h want 0", p0_rd_data | p1_rd_data); end
        @(posedge clk); #1;
        rst = 1'b0; b_rst = 1'b0;
    endtask

    task automatic test_hit;
        pre_we = 1'b1; pre_idx = 8'd16; pre_dat = 32'h1234_5678;
        tick;
        pre_we = 1'b0;
        p0_rd_req = 1'b1; p0_addr = 32'h40;
        tick;
        checks++; if (c_rd_req !== 1'b1) begin errs++; $display("FAIL hit_c_rd_req: got %0b want 1", c_rd_req); end
        checks++; if (c_addr !== 32'h40) begin errs++; $display("FAIL hit_c_addr: got %h want 00000040", c_addr); end
        checks++; if (busy !== 1'b1 || p0_done !== 1'b0) begin errs++; $display("FAIL hit_active: busy=%0b done=%0b want 1/0", busy, p0_done); end
        tick;
        checks++; if (p0_done !== 1'b1) begin errs++; $display("FAIL hit_done: got %0b want 1", p0_done); end
        checks++; if (p0_rd_data !== 32'h1234_5678) begin errs++; $display("FAIL hit_rd_data: got %h want 12345678", p0_rd_data); end
        checks++; if (c_rd_req !== 1'b0) begin errs++; $display("FAIL hit_resp_c_rd_req: got %0b want 0", c_rd_req); end
        checks++; if (p0_acc_cnt !== 32'd1 || p0_miss_cyc !== 32'd0) begin errs++; $display("FAIL hit_counters: acc=%0d miss=%0d want 1/0", p0_acc_cnt, p0_miss_cyc); end
        p0_rd_req = 1'b0;
        tick;
        checks++; if (p0_done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL hit_idle: done=%0b busy=%0b want 0/0", p0_done, busy); end
        checks++; if (p0_rd_data !== 32'h1234_5678) begin errs++; $display("FAIL hit_rd_hold: got %h want 12345678", p0_rd_data); end
    endtask

    task automatic test_miss_write;
        int cyc, wr_cyc;
        logic seen;
        cyc = 0; wr_cyc = 0; seen = 1'b0;
        p1_wr_req = 1'b1; p1_addr = 32'h80; p1_wr_data = 32'hDEAD_BEEF; c_miss = 1'b1;
        while (!seen && cyc < 30) begin
            tick;
            cyc++;
            if (c_wr_req) wr_cyc++;
            if (p1_done) seen = 1'b1;
            if (cyc == 6) c_miss = 1'b0;
        end
        c_miss = 1'b0;
        checks++; if (cyc !== 7) begin errs++; $display("FAIL miss_done_cycle: got %0d want 7", cyc); end
        checks++; if (wr_cyc !== 6) begin errs++; $display("FAIL miss_wr_cycles: got %0d want 6", wr_cyc); end
        checks++; if (p1_miss_cyc !== 32'd5) begin errs++; $display("FAIL miss_cyc_count: got %0d want 5", p1_miss_cyc); end
        checks++; if (p1_acc_cnt !== 32'd1) begin errs++; $display("FAIL miss_acc_count: got %0d want 1", p1_acc_cnt); end
        p1_wr_req = 1'b0;
        tick;
        p0_rd_req = 1'b1; p0_addr = 32'h80;
        tick; tick;
        checks++; if (p0_done !== 1'b1 || p0_rd_data !== 32'hDEAD_BEEF) begin errs++; $display("FAIL miss_readback: done=%0b data=%h want 1/deadbeef", p0_done, p0_rd_data); end
        p0_rd_req = 1'b0;
        tick;
    endtask

    task automatic test_round_robin;
        logic [3:0] order, exp_order;
        int n, cyc;
        n = 0; cyc = 0; order = '0; exp_order = 4'b1010;
        rst = 1'b1; tick; rst = 1'b0;
        p0_rd_req = 1'b1; p0_addr = 32'h40;
        p1_rd_req = 1'b1; p1_addr = 32'h80;
        while (n < 4 && cyc < 40) begin
            tick; cyc++;
            if (p0_done) begin order[n] = 1'b0; n++; end
            else if (p1_done) begin order[n] = 1'b1; n++; end
        end
        p0_rd_req = 1'b0; p1_rd_req = 1'b0;
        tick; tick;
        checks++; if (n !== 4) begin errs++; $display("FAIL rr_timeout: got %0d accesses want 4", n); end
        checks++; if (order !== exp_order) begin errs++; $display("FAIL rr_order: got %b want %b (bit0 first)", order, exp_order); end
        checks++; if (p0_acc_cnt !== 32'd2 || p1_acc_cnt !== 32'd2) begin errs++; $display("FAIL rr_counts: p0=%0d p1=%0d want 2/2", p0_acc_cnt, p1_acc_cnt); end
    endtask

    task automatic test_fixed_priority;
        logic [3:0] order;
        int n, cyc;
        n = 0; cyc = 0; order = 4'hF;
        b_rst = 1'b1; tick; b_rst = 1'b0;
        b_p0_rd = 1'b1; b_p1_rd = 1'b1;
        while (n < 4 && cyc < 40) begin
            tick; cyc++;
            if (f_p0_done) begin order[n] = 1'b0; n++; end
            else if (f_p1_done) begin order[n] = 1'b1; n++; end
        end
        b_p0_rd = 1'b0; b_p1_rd = 1'b0;
        tick; tick;
        checks++; if (n !== 4) begin errs++; $display("FAIL fp_timeout: got %0d accesses want 4", n); end
        checks++; if (order !== 4'b0000) begin errs++; $display("FAIL fp_order: got %b want 0000", order); end
        checks++; if (f_p0_acc !== 32'd4 || f_p1_acc !== 32'd0) begin errs++; $display("FAIL fp_counts: p0=%0d p1=%0d want 4/0", f_p0_acc, f_p1_acc); end
    endtask

    task automatic test_rd_wr_both;
        pre_we = 1'b1; pre_idx = 8'd4; pre_dat = 32'h55AA_55AA;
        tick;
        pre_we = 1'b0;
        p0_rd_req = 1'b1; p0_wr_req = 1'b1; p0_addr = 32'h10; p0_wr_data = 32'hBAD0_BAD0;
        tick;
        checks++; if (c_rd_req !== 1'b1 || c_wr_req !== 1'b0) begin errs++; $display("FAIL rdwr_strobes: rd=%0b wr=%0b want 1/0", c_rd_req, c_wr_req); end
        tick;
        checks++; if (p0_done !== 1'b1 || p0_rd_data !== 32'h55AA_55AA) begin errs++; $display("FAIL rdwr_data: done=%0b data=%h want 1/55aa55aa", p0_done, p0_rd_data); end
        p0_rd_req = 1'b0; p0_wr_req = 1'b0;
        tick;
        checks++; if (mem[4] !== 32'h55AA_55AA) begin errs++; $display("FAIL rdwr_mem_unchanged: got %h want 55aa55aa", mem[4]); end
    endtask

    task automatic test_reset_mid;
        logic saw_done;
        saw_done = 1'b0;
        p1_rd_req = 1'b1; p1_addr = 32'h40; c_miss = 1'b1;
        tick; tick;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rstmid_active: busy=%0b want 1", busy); end
        rst = 1'b1;
        #1; saw_done = p1_done;
        tick;
        saw_done = saw_done | p1_done;
        checks++; if (saw_done !== 1'b0) begin errs++; $display("FAIL rstmid_no_done: got %0b want 0", saw_done); end
        checks++; if ({busy, owner, c_rd_req, p1_done} !== 4'b0) begin errs++; $display("FAIL rstmid_outputs: got %b want 0000", {busy, owner, c_rd_req, p1_done}); end
        checks++; if ((p0_acc_cnt | p1_acc_cnt | p1_miss_cyc | p1_rd_data | p0_rd_data) !== 32'h0) begin errs++; $display("FAIL rstmid_clear: got %h want 0", p0_acc_cnt | p1_acc_cnt | p1_miss_cyc | p1_rd_data | p0_rd_data); end
        rst = 1'b0; c_miss = 1'b0;
        tick; tick;
        checks++; if (p1_done !== 1'b1 || p1_rd_data !== 32'h1234_5678) begin errs++; $display("FAIL rstmid_recover: done=%0b data=%h want 1/12345678", p1_done, p1_rd_data); end
        p1_rd_req = 1'b0;
        tick;
        checks++; if (p1_acc_cnt !== 32'd1) begin errs++; $display("FAIL rstmid_acc: got %0d want 1", p1_acc_cnt); end
    endtask

    task automatic test_saturate;
        b_rst = 1'b1; tick; b_rst = 1'b0;
        b_miss = 1'b1; b_p0_rd = 1'b1;
        tick;
        for (int k = 2; k <= 17; k++) begin
            tick;
            if (k == 15) begin
                checks++; if (s_p0_miss !== 4'hE) begin errs++; $display("FAIL sat_count14: got %h want e", s_p0_miss); end
            end
            if (k == 16) begin
                checks++; if (s_p0_miss !== 4'hF) begin errs++; $display("FAIL sat_count15: got %h want f", s_p0_miss); end
            end
        end
        checks++; if (s_p0_miss !== 4'hF) begin errs++; $display("FAIL sat_hold: got %h want f", s_p0_miss); end
        b_miss = 1'b0;
        tick;
        checks++; if (s_p0_done !== 1'b1 || s_p0_acc !== 4'd1) begin errs++; $display("FAIL sat_finish: done=%0b acc=%0d want 1/1", s_p0_done, s_p0_acc); end
        b_p0_rd = 1'b0;
        tick;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; b_rst = 1'b1;
        p0_rd_req = 1'b0; p0_wr_req = 1'b0; p0_addr = '0; p0_wr_data = '0;
        p1_rd_req = 1'b0; p1_wr_req = 1'b0; p1_addr = '0; p1_wr_data = '0;
        c_miss = 1'b0; b_p0_rd = 1'b0; b_p1_rd = 1'b0; b_miss = 1'b0; b_zero = '0;
        pre_we = 1'b0; pre_idx = '0; pre_dat = '0;
        test_reset;
        test_hit;
        test_miss_write;
        test_round_robin;
        test_fixed_priority;
        test_rd_wr_both;
        test_reset_mid;
        test_saturate;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
